ahb_bm_dma_input_stage: RTL and testbench
=========================================

Name: ahb_bm_dma_input_stage

Overview:
Per-master input stage of the DMA bus matrix. It sits between one master port and the address decoder / output stages.
- Registers an address phase the matrix cannot accept immediately, and replays it until an output stage takes it.
- Inserts wait states on the master port while the address is held.
- Returns data-phase HREADY/HRESP from the selected slave, including the default slave error response for unmapped addresses.

Parameters:
ADDR_WIDTH, 32, width of HADDRS/ADDRO

Ports:
HCLK  in  1  AHB clock
HRESETn  in  1  async active-low reset
HSELS  in  1  master-port select
HADDRS  in  ADDR_WIDTH  master address
HTRANSS  in  2  master transfer type
HWRITES  in  1  master write flag
HSIZES  in  3  master size
HBURSTS  in  3  master burst
HPROTS  in  4  master protection
HREADYS  in  1  master-layer HREADY
HREADYOUTS  out  1  ready returned to master
HRESPS  out  2  response returned to master
SELO  out  1  valid address phase offered to matrix
ADDRO  out  ADDR_WIDTH  offered address
TRANSO  out  2  offered HTRANS
WRITEO  out  1  offered write flag
SIZEO  out  3  offered size
BURSTO  out  3  offered burst
PROTO  out  4  offered protection
ADDR_ACCEPT  in  1  output stage took the offered address this cycle
READYIN  in  1  data-phase HREADY from selected slave (incl. default slave)
RESPIN  in  2  data-phase HRESP from selected slave

Behaviour:
- Reset HRESETn: asynchronous, active-low. Clock HCLK: rising edge.
- Encodings: HTRANS IDLE=00, BUSY=01, NONSEQ=10, SEQ=11. HRESP OKAY=00, ERROR=01, RETRY=10, SPLIT=11.
- Terms:
  - live_valid = HSELS & HREADYS & HTRANSS[1].
  - State bits: pend (address held) and dphase (accepted transfer in data phase).
- Reset values: pend=0, dphase=0, holding regs=0, HREADYOUTS=1, HRESPS=OKAY, SELO=0.
- Holding register:
  - When live_valid & ~ADDR_ACCEPT & ~pend, capture HADDRS/HTRANSS/HWRITES/HSIZES/HBURSTS/HPROTS and set pend.
  - pend clears on the cycle ADDR_ACCEPT=1 while pend.
  - While pend, captured values are frozen.
  - Master inputs are ignored while pend (master is stalled by HREADYOUTS=0).
- Offered address mux (combinational):
  - pend=1: SELO=1 and *O driven from the holding regs.
  - pend=0: SELO=live_valid and *O driven from live inputs (zero-latency pass-through).
- dphase update, evaluated in priority order:
  - Set when SELO & ADDR_ACCEPT.
  - Else clear when READYIN=1.
  - Else hold.
  - Accept and completion in the same cycle (back-to-back pipelined) leave dphase=1.
- HREADYOUTS / HRESPS (combinational):
  - pend=1: 0 / OKAY.
  - pend=0 and dphase=1: READYIN / RESPIN.
  - Otherwise: 1 / OKAY. This covers IDLE/BUSY transfers, HSELS=0, and a master that has not yet seen any transfer accepted.
- pend and dphase are mutually exclusive: capture requires HREADYS=1, which ends the previous data phase. A bench assertion flags pend & dphase.
- Two-cycle ERROR (RESPIN=ERROR, READYIN 0 then 1) passes through unchanged.
- Transfer cancellation by the master during ERROR cycle 2 is naturally honoured: an IDLE address with HREADYS=1 produces no capture.
- BUSY is never offered: TRANSS[1]=0 gives SELO=0.
- SEQ beats follow the same capture/replay rules as NONSEQ.
- Reset mid-operation (pend or dphase set): all state returns to reset values asynchronously and no replay occurs after reset release.
- ADDR_ACCEPT while SELO=0 is ignored.

Decomposition:
- Shared package ahb_bm_dma_pkg holds the HTRANS and HRESP encoding constants, shared with the default slave and output stages.
- One sub-module is natural: ahb_bm_dma_addr_hold, the holding register plus pend flag.
- The dphase and response mux stay in the top level.

Test Plan:
- Zero-wait pass-through: NONSEQ write to 0x2000_0010 with ADDR_ACCEPT=1 and READYIN=1 next cycle → SELO=1 and ADDRO=0x2000_0010 same cycle, no pend, HREADYOUTS=1 on both cycles.
- Held address: NONSEQ read to 0x4000_0000 with ADDR_ACCEPT=0 for 3 cycles, then 1:
  - HREADYOUTS=0 for 3 cycles, and ADDRO stays 0x4000_0000 while HADDRS changes to 0xDEAD_BEEF.
  - pend clears on the accept cycle.
  - Data phase follows READYIN.
- Default-slave error: accepted transfer, then RESPIN=ERROR with READYIN=0 then 1 → HRESPS=ERROR both cycles, HREADYOUTS 0 then 1, dphase clears. Master IDLE in cycle 2 → SELO=0.
- IDLE/BUSY: HTRANSS=00 then 01 with HSELS=1 and HREADYS=1 → SELO=0, HREADYOUTS=1, HRESPS=OKAY, no state change.
- Pipelined burst: INCR4 with ADDR_ACCEPT=1 every beat and READYIN=1 → dphase stays 1 across beats, four offered addresses 0x100/0x104/0x108/0x10C, then dphase clears.
- Reset mid-operation: assert HRESETn=0 while pend=1 → HREADYOUTS=1 and SELO=0 immediately; after release, no replay of the held address.

Source files
------------

// File: rtl/ahb_bm_dma_pkg.sv
// ahb_bm_dma_pkg
// Encoding constants shared by the DMA bus-matrix blocks.
// These are the HTRANS and HRESP codes used by the input stages,
// the output stages and the default slave.
// No ports; import with "import ahb_bm_dma_pkg::*;".
package ahb_bm_dma_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [1:0] HRESP_RETRY   = 2'b10;
  localparam logic [1:0] HRESP_SPLIT   = 2'b11;

  // NONSEQ and SEQ both have bit 1 set. IDLE and BUSY never start a
  // transfer.
  function automatic logic trans_is_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_bm_dma_addr_hold.sv
// ahb_bm_dma_addr_hold
// Holding register for one master's address phase.
// When the matrix does not accept a valid address phase, this block
// captures it and raises pend. The captured values stay frozen until
// addr_accept arrives while pend is high.
// Ports:
//   HCLK, HRESETn      clock, async active-low reset
//   live_valid         valid address phase on the master port
//   addr_accept        output stage took the offered address
//   haddr..hprot       live master address-phase signals
//   pend               an address is being held
//   hold_addr..prot    captured address-phase signals
module ahb_bm_dma_addr_hold
  import ahb_bm_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  live_valid,
  input  logic                  addr_accept,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  output logic                  pend,
  output logic [ADDR_WIDTH-1:0] hold_addr,
  output logic [1:0]            hold_trans,
  output logic                  hold_write,
  output logic [2:0]            hold_size,
  output logic [2:0]            hold_burst,
  output logic [3:0]            hold_prot
);

  logic                  pend_r;
  logic                  capture_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [1:0]            trans_r;
  logic                  write_r;
  logic [2:0]            size_r;
  logic [2:0]            burst_r;
  logic [3:0]            prot_r;

  // Capture only when nothing is held yet. While pend is high the
  // master is stalled, so its inputs are ignored.
  assign capture_s = live_valid & ~addr_accept & ~pend_r;

  // Pend flag: set on capture, cleared when the held address is taken.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_r <= 1'b0;
    end else if (pend_r) begin
      pend_r <= ~addr_accept;
    end else begin
      pend_r <= capture_s;
    end
  end

  // Address-phase holding registers: loaded on capture, frozen otherwise.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_r  <= {ADDR_WIDTH{1'b0}};
      trans_r <= HTRANS_IDLE;
      write_r <= 1'b0;
      size_r  <= 3'b000;
      burst_r <= 3'b000;
      prot_r  <= 4'b0000;
    end else if (capture_s) begin
      addr_r  <= haddr;
      trans_r <= htrans;
      write_r <= hwrite;
      size_r  <= hsize;
      burst_r <= hburst;
      prot_r  <= hprot;
    end else begin
      addr_r  <= addr_r;
      trans_r <= trans_r;
      write_r <= write_r;
      size_r  <= size_r;
      burst_r <= burst_r;
      prot_r  <= prot_r;
    end
  end

  assign pend       = pend_r;
  assign hold_addr  = addr_r;
  assign hold_trans = trans_r;
  assign hold_write = write_r;
  assign hold_size  = size_r;
  assign hold_burst = burst_r;
  assign hold_prot  = prot_r;

endmodule

// File: rtl/ahb_bm_dma_input_stage.sv
// ahb_bm_dma_input_stage
// Per-master input stage of the DMA bus matrix.
// It offers the master's address phase to the matrix. If the matrix
// cannot take it at once, the address is held and replayed, and wait
// states go back to the master. It also returns the data-phase
// HREADY/HRESP of the selected slave to the master.
// Ports:
//   HCLK, HRESETn                     clock, async active-low reset
//   HSELS..HREADYS                    master-port address phase and layer HREADY
//   HREADYOUTS, HRESPS                ready/response returned to the master
//   SELO, ADDRO..PROTO                address phase offered to the matrix
//   ADDR_ACCEPT                       output stage took the offered address
//   READYIN, RESPIN                   data-phase ready/response from the slave
module ahb_bm_dma_input_stage
  import ahb_bm_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [3:0]            HPROTS,
  input  logic                  HREADYS,
  output logic                  HREADYOUTS,
  output logic [1:0]            HRESPS,
  output logic                  SELO,
  output logic [ADDR_WIDTH-1:0] ADDRO,
  output logic [1:0]            TRANSO,
  output logic                  WRITEO,
  output logic [2:0]            SIZEO,
  output logic [2:0]            BURSTO,
  output logic [3:0]            PROTO,
  input  logic                  ADDR_ACCEPT,
  input  logic                  READYIN,
  input  logic [1:0]            RESPIN
);

  logic                  live_valid_s;
  logic                  pend_s;
  logic [ADDR_WIDTH-1:0] hold_addr_s;
  logic [1:0]            hold_trans_s;
  logic                  hold_write_s;
  logic [2:0]            hold_size_s;
  logic [2:0]            hold_burst_s;
  logic [3:0]            hold_prot_s;
  logic                  dphase_r;
  logic                  dphase_next_s;

  assign live_valid_s = HSELS & HREADYS & trans_is_active(HTRANSS);

  ahb_bm_dma_addr_hold #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_hold (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .live_valid  (live_valid_s),
    .addr_accept (ADDR_ACCEPT),
    .haddr       (HADDRS),
    .htrans      (HTRANSS),
    .hwrite      (HWRITES),
    .hsize       (HSIZES),
    .hburst      (HBURSTS),
    .hprot       (HPROTS),
    .pend        (pend_s),
    .hold_addr   (hold_addr_s),
    .hold_trans  (hold_trans_s),
    .hold_write  (hold_write_s),
    .hold_size   (hold_size_s),
    .hold_burst  (hold_burst_s),
    .hold_prot   (hold_prot_s)
  );

  // Offered address mux: the held phase wins, else the live phase passes through.
  always_comb begin
    SELO   = live_valid_s;
    ADDRO  = HADDRS;
    TRANSO = HTRANSS;
    WRITEO = HWRITES;
    SIZEO  = HSIZES;
    BURSTO = HBURSTS;
    PROTO  = HPROTS;
    if (pend_s) begin
      SELO   = 1'b1;
      ADDRO  = hold_addr_s;
      TRANSO = hold_trans_s;
      WRITEO = hold_write_s;
      SIZEO  = hold_size_s;
      BURSTO = hold_burst_s;
      PROTO  = hold_prot_s;
    end else begin
      SELO   = live_valid_s;
    end
  end

  // Data-phase tracking. A new accept outranks completion, so
  // back-to-back pipelined beats keep dphase high.
  always_comb begin
    dphase_next_s = dphase_r;
    if (SELO && ADDR_ACCEPT) begin
      dphase_next_s = 1'b1;
    end else if (READYIN) begin
      dphase_next_s = 1'b0;
    end else begin
      dphase_next_s = dphase_r;
    end
  end

  // Data-phase flag register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dphase_r <= 1'b0;
    end else begin
      dphase_r <= dphase_next_s;
    end
  end

  // Master response: stall while an address is held, otherwise forward
  // the slave's data-phase response when this master owns one.
  always_comb begin
    HREADYOUTS = 1'b1;
    HRESPS     = HRESP_OKAY;
    if (pend_s) begin
      HREADYOUTS = 1'b0;
      HRESPS     = HRESP_OKAY;
    end else if (dphase_r) begin
      HREADYOUTS = READYIN;
      HRESPS     = RESPIN;
    end else begin
      HREADYOUTS = 1'b1;
      HRESPS     = HRESP_OKAY;
    end
  end

endmodule

// File: tb/tb_ahb_bm_dma_input_stage.sv
// tb_ahb_bm_dma_input_stage
// Self-checking bench for ahb_bm_dma_input_stage. A vector table drives
// one cycle per entry. The expected outputs go into a scoreboard queue
// and are compared on the falling edge. Hand-written sequences then
// cover the frozen sideband fields and reset in the middle of a hold.
module tb_ahb_bm_dma_input_stage;
  import ahb_bm_dma_pkg::*;

  logic        HCLK;
  logic        HRESETn;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic        HREADYS;
  logic        HREADYOUTS;
  logic [1:0]  HRESPS;
  logic        SELO;
  logic [31:0] ADDRO;
  logic [1:0]  TRANSO;
  logic        WRITEO;
  logic [2:0]  SIZEO;
  logic [2:0]  BURSTO;
  logic [3:0]  PROTO;
  logic        ADDR_ACCEPT;
  logic        READYIN;
  logic [1:0]  RESPIN;

  int n_pass  = 0;
  int n_total = 0;

  ahb_bm_dma_input_stage #(.ADDR_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
    .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
    .HPROTS(HPROTS), .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
    .SELO(SELO), .ADDRO(ADDRO), .TRANSO(TRANSO), .WRITEO(WRITEO), .SIZEO(SIZEO),
    .BURSTO(BURSTO), .PROTO(PROTO), .ADDR_ACCEPT(ADDR_ACCEPT), .READYIN(READYIN),
    .RESPIN(RESPIN)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        hsels;
    logic        hreadys;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hburst;
    logic        accept;
    logic        readyin;
    logic [1:0]  respin;
    logic        e_ready;
    logic [1:0]  e_resp;
    logic        e_selo;
    logic [31:0] e_addr;
    logic [1:0]  e_trans;
    logic        e_write;
    logic [2:0]  e_burst;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];
  logic [41:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  function automatic vec_t mk(
    input logic s, input logic r, input logic [1:0] t, input logic [31:0] a,
    input logic w, input logic [2:0] b, input logic acc, input logic rin,
    input logic [1:0] rsp, input logic er, input logic [1:0] ersp, input logic esel,
    input logic [31:0] ea, input logic [1:0] et, input logic ew, input logic [2:0] eb);
    vec_t v;
    v.hsels = s; v.hreadys = r; v.htrans = t; v.haddr = a; v.hwrite = w;
    v.hburst = b; v.accept = acc; v.readyin = rin; v.respin = rsp;
    v.e_ready = er; v.e_resp = ersp; v.e_selo = esel; v.e_addr = ea;
    v.e_trans = et; v.e_write = ew; v.e_burst = eb;
    return v;
  endfunction

  // Held address and active data phase must never coexist.
  always @(negedge HCLK) begin
    if (HRESETn) chk("pend_dphase_excl", {63'd0, dut.pend_s & dut.dphase_r}, 64'd0);
  end

  initial begin
    logic [41:0] got;
    logic [41:0] expv;
    logic [1:0] ns, sq, id, bz, ok, er;
    ns = HTRANS_NONSEQ; sq = HTRANS_SEQ; id = HTRANS_IDLE; bz = HTRANS_BUSY;
    ok = HRESP_OKAY; er = HRESP_ERROR;

    // zero-wait pass-through
    vecs[0]  = mk(1'b1,1'b1,ns,32'h2000_0010,1'b1,3'b000, 1'b1,1'b1,ok, 1'b1,ok,1'b1,32'h2000_0010,ns,1'b1,3'b000);
    vecs[1]  = mk(1'b1,1'b1,id,32'h0,1'b0,3'b000, 1'b0,1'b1,ok, 1'b1,ok,1'b0,32'h0,id,1'b0,3'b000);
    // held address, replay, then data phase
    vecs[2]  = mk(1'b1,1'b1,ns,32'h4000_0000,1'b0,3'b000, 1'b0,1'b1,ok, 1'b1,ok,1'b1,32'h4000_0000,ns,1'b0,3'b000);
    vecs[3]  = mk(1'b1,1'b0,ns,32'hDEAD_BEEF,1'b1,3'b111, 1'b0,1'b0,ok, 1'b0,ok,1'b1,32'h4000_0000,ns,1'b0,3'b000);
    vecs[4]  = mk(1'b1,1'b0,ns,32'hDEAD_BEEF,1'b1,3'b111, 1'b0,1'b0,ok, 1'b0,ok,1'b1,32'h4000_0000,ns,1'b0,3'b000);
    vecs[5]  = mk(1'b1,1'b0,ns,32'hDEAD_BEEF,1'b1,3'b111, 1'b1,1'b0,ok, 1'b0,ok,1'b1,32'h4000_0000,ns,1'b0,3'b000);
    vecs[6]  = mk(1'b1,1'b0,id,32'h0,1'b0,3'b000, 1'b0,1'b0,ok, 1'b0,ok,1'b0,32'h0,id,1'b0,3'b000);
    vecs[7]  = mk(1'b1,1'b1,id,32'h0,1'b0,3'b000, 1'b0,1'b1,ok, 1'b1,ok,1'b0,32'h0,id,1'b0,3'b000);
    // default-slave two-cycle error, master cancels in cycle 2, stray accept ignored
    vecs[8]  = mk(1'b1,1'b1,ns,32'h6000_0000,1'b0,3'b000, 1'b1,1'b1,ok, 1'b1,ok,1'b1,32'h6000_0000,ns,1'b0,3'b000);
    vecs[9]  = mk(1'b1,1'b0,ns,32'h6000_0004,1'b0,3'b000, 1'b0,1'b0,er, 1'b0,er,1'b0,32'h6000_0004,ns,1'b0,3'b000);
    vecs[10] = mk(1'b1,1'b1,id,32'h0,1'b0,3'b000, 1'b1,1'b1,er, 1'b1,er,1'b0,32'h0,id,1'b0,3'b000);
    vecs[11] = mk(1'b1,1'b1,id,32'h0,1'b0,3'b000, 1'b0,1'b0,er, 1'b1,ok,1'b0,32'h0,id,1'b0,3'b000);
    // IDLE / BUSY / unselected never offered or captured
    vecs[12] = mk(1'b1,1'b1,id,32'h1234,1'b0,3'b000, 1'b0,1'b0,ok, 1'b1,ok,1'b0,32'h1234,id,1'b0,3'b000);
    vecs[13] = mk(1'b1,1'b1,bz,32'h1238,1'b0,3'b000, 1'b0,1'b0,ok, 1'b1,ok,1'b0,32'h1238,bz,1'b0,3'b000);
    vecs[14] = mk(1'b0,1'b1,ns,32'h5000,1'b0,3'b000, 1'b0,1'b0,ok, 1'b1,ok,1'b0,32'h5000,ns,1'b0,3'b000);
    vecs[15] = mk(1'b1,1'b1,id,32'h0,1'b0,3'b000, 1'b0,1'b0,ok, 1'b1,ok,1'b0,32'h0,id,1'b0,3'b000);
    // pipelined INCR4
    vecs[16] = mk(1'b1,1'b1,ns,32'h100,1'b0,3'b011, 1'b1,1'b1,ok, 1'b1,ok,1'b1,32'h100,ns,1'b0,3'b011);
    vecs[17] = mk(1'b1,1'b1,sq,32'h104,1'b0,3'b011, 1'b1,1'b1,ok, 1'b1,ok,1'b1,32'h104,sq,1'b0,3'b011);
    vecs[18] = mk(1'b1,1'b1,sq,32'h108,1'b0,3'b011, 1'b1,1'b1,ok, 1'b1,ok,1'b1,32'h108,sq,1'b0,3'b011);
    vecs[19] = mk(1'b1,1'b1,sq,32'h10C,1'b0,3'b011, 1'b1,1'b1,ok, 1'b1,ok,1'b1,32'h10C,sq,1'b0,3'b011);
    vecs[20] = mk(1'b1,1'b1,id,32'h0,1'b0,3'b000, 1'b1,1'b1,ok, 1'b1,ok,1'b0,32'h0,id,1'b0,3'b000);
    vecs[21] = mk(1'b1,1'b1,id,32'h0,1'b0,3'b000, 1'b0,1'b0,ok, 1'b1,ok,1'b0,32'h0,id,1'b0,3'b000);

    HRESETn = 1'b0; HSELS = 1'b0; HADDRS = 32'h0; HTRANSS = id; HWRITES = 1'b0;
    HSIZES = 3'b010; HBURSTS = 3'b000; HPROTS = 4'b0011; HREADYS = 1'b1;
    ADDR_ACCEPT = 1'b0; READYIN = 1'b1; RESPIN = ok;
    #1;
    chk("reset_outputs", {61'd0, HREADYOUTS, HRESPS, SELO}, {61'd0, 1'b1, ok, 1'b0});
    @(negedge HCLK);
    HRESETn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge HCLK);
      #1;
      HSELS = vecs[i].hsels; HREADYS = vecs[i].hreadys; HTRANSS = vecs[i].htrans;
      HADDRS = vecs[i].haddr; HWRITES = vecs[i].hwrite; HBURSTS = vecs[i].hburst;
      ADDR_ACCEPT = vecs[i].accept; READYIN = vecs[i].readyin; RESPIN = vecs[i].respin;
      exp_q.push_back({vecs[i].e_ready, vecs[i].e_resp, vecs[i].e_selo, vecs[i].e_addr,
                       vecs[i].e_trans, vecs[i].e_write, vecs[i].e_burst});
      @(negedge HCLK);
      got  = {HREADYOUTS, HRESPS, SELO, ADDRO, TRANSO, WRITEO, BURSTO};
      expv = exp_q.pop_front();
      chk($sformatf("vec%0d", i), {22'd0, got}, {22'd0, expv});
    end

    // Hold with distinctive size/prot, then reset while pend is set.
    @(posedge HCLK);
    #1;
    HSELS = 1'b1; HREADYS = 1'b1; HTRANSS = ns; HADDRS = 32'h7000_0000; HWRITES = 1'b1;
    HSIZES = 3'b001; HPROTS = 4'b1010; HBURSTS = 3'b000; ADDR_ACCEPT = 1'b0; READYIN = 1'b1;
    @(posedge HCLK);
    #1;
    HREADYS = 1'b0; HADDRS = 32'hFFFF_0000; HSIZES = 3'b111; HPROTS = 4'b0000; HWRITES = 1'b0;
    @(negedge HCLK);
    chk("hold_frozen", {HREADYOUTS, SELO, ADDRO, WRITEO, SIZEO, PROTO},
        {1'b0, 1'b1, 32'h7000_0000, 1'b1, 3'b001, 4'b1010});
    #2;
    HRESETn = 1'b0; HTRANSS = id;
    #1;
    chk("reset_async", {HREADYOUTS, HRESPS, SELO}, {1'b1, ok, 1'b0});
    @(negedge HCLK);
    HRESETn = 1'b1; HREADYS = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge HCLK);
      chk($sformatf("no_replay%0d", k), {HREADYOUTS, SELO}, {1'b1, 1'b0});
    end

    @(posedge HCLK);
    #1;
    HRESETn = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
